// File: rtl/pwm_capture.sv
// pwm_capture: measures an asynchronous PWM input and reports its period,
// high time and duty cycle, where duty = floor(high*2^CTR_LEN/period).
//
// Ports:
//   clk        single clock, all state on the rising edge
//   reset_n    asynchronous active-low reset
//   enable     1 = capture running; 0 = FSM idles, divider aborts, results held
//   pwm_in     asynchronous PWM input
//   duty       decoded duty cycle, saturated to all ones
//   period     last measured period in clk cycles
//   high_time  last measured high time in clk cycles
//   valid      one-cycle pulse when duty/period/high_time update
//   timeout    level, set when no rising edge is seen for 2^CNT_W-1 cycles
//   overrun    sticky, set when a measurement is dropped (divider busy)
module pwm_capture #(
  parameter int CTR_LEN = 6,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic               pwm_in,
  output logic [CTR_LEN-1:0] duty,
  output logic [CNT_W-1:0]   period,
  output logic [CNT_W-1:0]   high_time,
  output logic               valid,
  output logic               timeout,
  output logic               overrun
);

  localparam int DCW = $clog2(CTR_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
  state_t state, state_nxt;

  logic s1, s2, s3;
  logic rise, fall;
  logic [CNT_W-1:0] per_cnt, hi_cnt;
  logic cnt_load, per_inc, hi_inc, complete, tmo_evt;

  // divider state
  logic               busy, sat;
  logic [DCW-1:0]     dcnt;
  logic [CNT_W:0]     rem, trial, rem_nxt;
  logic [CNT_W-1:0]   dvs, hi_l;
  logic [CTR_LEN-1:0] q;
  logic               ge, last;

  // 2-flop synchronizer plus one delay stage for edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) {s1, s2, s3} <= '0;
    else          {s1, s2, s3} <= {pwm_in, s1, s2};
  end

  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

  // Timeout fires once; the held timeout flag suppresses repeats until a
  // rising edge restarts the measurement.
  assign tmo_evt = enable && (per_cnt == CNT_MAX) && !timeout;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!enable || tmo_evt) state_nxt = IDLE;
    else begin
      case (state)
        IDLE:    if (rise) state_nxt = HIGH;
        HIGH:    if (fall) state_nxt = LOW;
        LOW:     if (rise) state_nxt = HIGH;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_load = 1'b0;
    complete = 1'b0;
    per_inc  = 1'b0;
    hi_inc   = 1'b0;
    if (enable && !tmo_evt) begin
      case (state)
        // IDLE keeps counting so a dead input still produces a timeout
        IDLE: begin
          cnt_load = rise;
          per_inc  = !rise && !timeout && (per_cnt != CNT_MAX);
        end
        HIGH: begin
          per_inc = (per_cnt != CNT_MAX);
          hi_inc  = !fall && (hi_cnt != CNT_MAX);
        end
        LOW: begin
          cnt_load = rise;
          complete = rise;
          per_inc  = !rise && (per_cnt != CNT_MAX);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      per_cnt <= '0;
      hi_cnt  <= '0;
    end else if (!enable) begin
      per_cnt <= '0;
      hi_cnt  <= '0;
    end else if (cnt_load) begin
      per_cnt <= CNT_W'(1);
      hi_cnt  <= CNT_W'(1);
    end else begin
      if (per_inc) per_cnt <= per_cnt + 1'b1;
      if (hi_inc)  hi_cnt  <= hi_cnt + 1'b1;
    end
  end

  // Restoring divider. Step 0 only tests high >= period (the saturation
  // bit); steps 1..CTR_LEN shift the remainder and produce one quotient
  // bit each. While unsaturated, rem < dvs so the shift fits CNT_W+1 bits.
  assign trial   = (dcnt == '0) ? rem : {rem[CNT_W-1:0], 1'b0};
  assign ge      = trial >= {1'b0, dvs};
  assign rem_nxt = ge ? trial - {1'b0, dvs} : trial;
  assign last    = (dcnt == DCW'(CTR_LEN));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy      <= 1'b0;
      sat       <= 1'b0;
      dcnt      <= '0;
      rem       <= '0;
      dvs       <= '0;
      hi_l      <= '0;
      q         <= '0;
      duty      <= '0;
      period    <= '0;
      high_time <= '0;
      valid     <= 1'b0;
      timeout   <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (!enable) begin
        busy <= 1'b0;
      end else begin
        if (busy) begin
          rem  <= rem_nxt;
          dcnt <= dcnt + 1'b1;
          if (dcnt == '0) sat <= ge;
          else            q   <= {q[CTR_LEN-2:0], ge};
          if (last) begin
            busy      <= 1'b0;
            valid     <= 1'b1;
            duty      <= sat ? '1 : {q[CTR_LEN-2:0], ge};
            period    <= dvs;
            high_time <= hi_l;
          end
        end
        if (complete) begin
          if (busy) overrun <= 1'b1;
          else begin
            busy <= 1'b1;
            dcnt <= '0;
            sat  <= 1'b0;
            q    <= '0;
            rem  <= {1'b0, hi_cnt};
            dvs  <= per_cnt;
            hi_l <= hi_cnt;
          end
        end
        if (cnt_load) timeout <= 1'b0;
        if (tmo_evt) begin
          timeout   <= 1'b1;
          valid     <= 1'b1;
          duty      <= s2 ? '1 : '0;
          period    <= '1;
          high_time <= '1;
        end
      end
    end
  end

endmodule

// File: doc/pwm_capture.md
PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 Parameter CTR_LEN, default 6: width of the decoded duty value (2^CTR_LEN linear steps).
REQ-002 Parameter CNT_W, default 16: width of the period/high-time counters.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 enable  input  1  1 = capture running; 0 = FSM forced to IDLE, result outputs held.
REQ-006 pwm_in  input  1  asynchronous PWM signal to be decoded.
REQ-007 duty  output  CTR_LEN  decoded duty cycle, floor(high*2^CTR_LEN/period), saturated.
REQ-008 period  output  CNT_W  last measured period in clk cycles.
REQ-009 high_time  output  CNT_W  last measured high time in clk cycles.
REQ-010 valid  output  1  one-cycle pulse when duty/period/high_time update.
REQ-011 timeout  output  1  level; 1 while no rising edge has been seen for 2^CNT_W-1 cycles.
REQ-012 overrun  output  1  sticky; set when a completed measurement is dropped; cleared only by reset.

Function
REQ-013 pwm_in SHALL pass through a 2-flop synchronizer; edges SHALL be detected from the synchronized signal and its 1-cycle delayed copy.
REQ-014 FSM states SHALL be IDLE, HIGH and LOW.
REQ-015 IDLE -> HIGH on a detected rising edge with enable=1; the period and high counters load 1.
REQ-016 HIGH: both counters increment each cycle; a detected falling edge freezes the high counter and moves to LOW.
REQ-017 LOW: the period counter increments; a detected rising edge completes the measurement and re-enters HIGH with both counters reloaded to 1, with no dead cycle.
REQ-018 On completion, period = cycles between consecutive detected rising edges and high_time = cycles from rising to falling detected edge; both SHALL be latched into the divider.
REQ-019 A restoring divider SHALL compute duty = floor(high_time*2^CTR_LEN/period) in CTR_LEN+1 cycles; a result >= 2^CTR_LEN SHALL saturate to all ones.
REQ-020 valid SHALL pulse exactly CTR_LEN+2 cycles after the cycle in which the completing rising edge is detected.
REQ-021 duty, period and high_time SHALL update in the same cycle as valid.
REQ-022 A measurement that completes while the divider is busy SHALL be dropped with overrun set; the in-flight division SHALL finish unaffected.
REQ-023 If the period counter reaches 2^CNT_W-1 in any state, the FSM SHALL go to IDLE and timeout SHALL assert.
REQ-024 On that timeout, duty SHALL be all ones if the synchronized pwm_in is 1 and 0 otherwise; period and high_time SHALL be all ones; valid SHALL pulse once.
REQ-025 timeout SHALL deassert on the next detected rising edge.
REQ-026 The counters SHALL never wrap.
REQ-027 enable=0 SHALL abort any measurement and division with no valid pulse; re-enable SHALL wait in IDLE for a fresh rising edge.

Reset
REQ-028 On reset_n=0: FSM=IDLE; counters, synchronizer, duty, period, high_time, valid, timeout and overrun = 0.
REQ-029 Reset during a measurement or division SHALL discard it with no valid pulse.
REQ-030 After reset_n deasserts, the first valid SHALL require two detected rising edges.

Verification
REQ-031 Drive a 64-cycle-period PWM with high time 20 -> valid each period; duty=20, period=64, high_time=20.
REQ-032 Hold pwm_in low, then separately high, for 2^CNT_W cycles (CNT_W=8 build) -> timeout=1; duty=0, then duty=63; period=255.
REQ-033 Period 64 with high time 63, then period 10 with high time 10 -> duty=63 both times; saturation produces no wrap.
REQ-034 Period 4 cycles, which is shorter than the divider latency -> overrun=1 and valid only every other period, with no corrupted values.
REQ-035 Assert reset_n=0 mid-HIGH, and separately mid-division -> all outputs 0 with no valid; the next result follows two rising edges.
REQ-036 Drop enable mid-LOW, then restore it -> no valid until the second rising edge after re-enable.
